// File: rtl/led_switch_and_pkg.sv
// Shared helpers and LED polarity constants for led_switch_and.
// Polarity follows LED_ACTIVE_LOW_EN: defined means the LED pin is active-low.
package led_switch_and_pkg;

    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

`ifdef LED_ACTIVE_LOW_EN
    localparam logic LED_ON = 1'b0;
`else
    localparam logic LED_ON = 1'b1;
`endif
    localparam logic LED_OFF = ~LED_ON;

endpackage

// File: rtl/switch_debouncer.sv
// One switch: SYNC_STAGES-deep synchronizer followed by a consecutive-cycle debounce counter.
module switch_debouncer
    import led_switch_and_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic deb
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic [CW-1:0]          cnt;
    logic                   sync;

    assign sync = sync_chain[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw};
        end
    end

    // cnt is cleared on reaching CNT_LAST, so it can never run past it and wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= 1'b0;
            cnt <= '0;
        end else if (sync == deb) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            deb <= sync;
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_switch_and.sv
// LED driven by the registered AND of two debounced slide switches.
// Build option LED_ACTIVE_LOW_EN inverts the LED pin (reset value becomes 1).
module led_switch_and
    import led_switch_and_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic switch_a,
    input  logic switch_b,
    output logic led
);

    logic deb_a;
    logic deb_b;

    switch_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_a (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (switch_a),
        .deb  (deb_a)
    );

    switch_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_b (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (switch_b),
        .deb  (deb_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= LED_OFF;
        end else begin
            led <= (deb_a & deb_b) ? LED_ON : LED_OFF;
        end
    end

endmodule

// File: tb/tb_led_switch_and.sv
// Directed bench for led_switch_and (defaults: SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Expected LED levels follow LED_ACTIVE_LOW_EN when the bench is built with it.
module tb_led_switch_and;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic ON = 1'b0;
`else
    localparam logic ON = 1'b1;
`endif
    localparam logic OFF = ~ON;

    logic clk = 1'b0;
    logic rst_n;
    logic switch_a;
    logic switch_b;
    logic led;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    led_switch_and #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .switch_a(switch_a),
        .switch_b(switch_b),
        .led     (led)
    );

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: led=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic lvl(input logic lit);
        return lit ? ON : OFF;
    endfunction

    logic [1:0] truth_vec [8] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b00};

    initial begin
        rst_n    = 1'b0;
        switch_a = 1'b1;
        switch_b = 1'b1;
        #2;
        chk("reset_immediate", led, OFF);
        repeat (3) tick();
        chk("reset_held", led, OFF);

        // Edge i=0 is the release edge; the held-high switches reach led at i=6.
        rst_n = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            tick();
            chk($sformatf("release_e%0d", i), led, lvl(i == 6));
        end

        // Asynchronous assertion mid-cycle clears led without a clock edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_reset", led, OFF);
        #1;
        rst_n = 1'b1;
        repeat (10) tick();
        chk("recover_after_reset", led, ON);

        foreach (truth_vec[t]) begin
            switch_a = truth_vec[t][1];
            switch_b = truth_vec[t][0];
            repeat (20) tick();
            chk($sformatf("truth_%0d_ab%b", t, truth_vec[t]), led, lvl(truth_vec[t][1] & truth_vec[t][0]));
        end

        // Latency: b rises just after an edge; next edge is k (i=0).
        switch_a = 1'b1;
        repeat (20) tick();
        switch_b = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            tick();
            chk($sformatf("latency_e%0d", i), led, lvl(i == 6));
        end

        // Glitch of DEBOUNCE_CYCLES-1 clocks is rejected.
        repeat (5) tick();
        for (int i = 0; i < 14; i++) begin
            switch_b = (i < 3) ? 1'b0 : 1'b1;
            tick();
            chk($sformatf("glitch3_e%0d", i), led, ON);
        end

        // A drop of exactly DEBOUNCE_CYCLES clocks is accepted.
        for (int i = 0; i <= 6; i++) begin
            switch_b = (i < 4) ? 1'b0 : 1'b1;
            tick();
        end
        chk("drop4_accepted", led, OFF);
        repeat (20) tick();
        chk("drop4_recovered", led, ON);

        // Bounce from a settled low: 2-clock pulses never qualify; settle at i=20.
        switch_b = 1'b0;
        repeat (20) tick();
        chk("bounce_start_low", led, OFF);
        for (int i = 0; i <= 26; i++) begin
            switch_b = (i >= 20) ? 1'b1 : (((i / 2) % 2) == 0);
            tick();
            chk($sformatf("bounce_e%0d", i), led, lvl(i >= 26));
        end

        // Falling edge of a with b still high.
        switch_a = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            tick();
            chk($sformatf("fall_a_e%0d", i), led, lvl(i != 6));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
